// File: rtl/piso_arbiter.sv
// piso_arbiter: round-robin controller sharing one PISO serializer among N_REQ requesters
// Ports:
//    clk       clock
//    rst       asynchronous active-high reset
//    req       per-requester request level
//    req_data  parallel words, requester i at [i*DEPTH*WIDTH +: DEPTH*WIDTH]
//    gnt       one-hot grant pulse (one cycle, coincides with piso_we)
//    piso_pi   registered word driven to the PISO parallel input
//    piso_we   PISO write-enable pulse
//    halt      shared PISO halt; a chunk shifts only on an edge with halt=0
//    busy      high from the grant cycle through the last shift
//    owner     index of the current or most recent grantee
//    done      one-cycle pulse after the last chunk has shifted
// Build option: define PISO_ARB_FIXED_PRIO_EN for fixed lowest-index priority
// (no rotating pointer); default is round-robin. Timing is the same in both modes.
module piso_arbiter #(
   parameter int N_REQ = 4,
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   localparam int OWNER_W = $clog2(N_REQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req,
   input  logic [N_REQ*DEPTH*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]             gnt,
   output logic [DEPTH*WIDTH-1:0]       piso_pi,
   output logic                         piso_we,
   input  logic                         halt,
   output logic                         busy,
   output logic [OWNER_W-1:0]           owner,
   output logic                         done
);
   localparam int DW = DEPTH * WIDTH;
   localparam int CW = $clog2(DEPTH + 1);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
   state_t             state;
   logic [CW-1:0]      cnt;
   logic [OWNER_W-1:0] sel;
`ifndef PISO_ARB_FIXED_PRIO_EN
   logic [OWNER_W-1:0] ptr;
`endif
   always_comb begin
`ifdef PISO_ARB_FIXED_PRIO_EN
      sel = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (req[i]) sel = OWNER_W'(i);
`else
      int                 j;
      logic [OWNER_W-1:0] k;
      sel = '0;
      j = 0;
      k = '0;
      // scan downward so the set bit nearest ptr (upward, wrapping) is assigned last and wins
      for (int i = N_REQ - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= N_REQ) j = j - N_REQ;
         k = OWNER_W'(j);
         if (req[k]) sel = k;
      end
`endif
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= '0;
         piso_pi <= '0;
         piso_we <= 1'b0;
         busy    <= 1'b0;
         owner   <= '0;
         done    <= 1'b0;
         cnt     <= '0;
`ifndef PISO_ARB_FIXED_PRIO_EN
         ptr     <= '0;
`endif
      end else begin
         gnt     <= '0;
         piso_we <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: if (|req) begin
               piso_pi <= req_data[int'(sel)*DW +: DW];
               gnt     <= N_REQ'(1) << sel;
               piso_we <= 1'b1;
               owner   <= sel;
               busy    <= 1'b1;
               cnt     <= CW'(DEPTH);
`ifndef PISO_ARB_FIXED_PRIO_EN
               ptr     <= (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;
`endif
               state   <= LOAD;
            end
            // PISO captures piso_pi on this edge; the counter starts moving on the next one
            LOAD: state <= SHIFT;
            SHIFT: if (!halt) begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_piso_arbiter.sv
// tb_piso_arbiter: scoreboard bench for piso_arbiter with a behavioural PISO model
module tb_piso_arbiter;
   localparam int N = 4, D = 8, W = 8, DW = D * W;
   logic            clk = 1'b0, rst, halt;
   logic [N-1:0]    req, gnt;
   logic [N*DW-1:0] req_data;
   logic [DW-1:0]   piso_pi;
   logic            piso_we, busy, done;
   logic [1:0]      owner;
   int pass_n = 0, total_n = 0, cyc = 0, n_done = 0, pcnt = 0;
   typedef struct {logic [N-1:0] g; logic [1:0] o; logic [DW-1:0] w;} gexp_t;
   gexp_t         gq[$];
   logic [W-1:0]  cq[$];
   logic [DW-1:0] sreg;
   piso_arbiter #(.N_REQ(N), .DEPTH(D), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
      .piso_pi(piso_pi), .piso_we(piso_we), .halt(halt), .busy(busy),
      .owner(owner), .done(done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total_n++;
      if (got === exp) pass_n++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   function automatic logic [DW-1:0] wd(input int i);
      return 64'h0102030405060708 + 64'h1010101010101010 * i;
   endfunction
   task automatic expect_txn(input int i);
      logic [DW-1:0] w;
      w = wd(i);
      gq.push_back('{g: N'(1) << i, o: 2'(i), w: w});
      for (int j = D - 1; j >= 0; j--) cq.push_back(w[j*W +: W]);
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic wait_gnt(output int t);
      int k;
      k = 0;
      do begin tick; k++; end while (gnt == 0 && k < 40);
      if (gnt == 0) check("gnt_timeout", 0, 1);
      t = cyc;
   endtask
   task automatic wait_done;
      int k;
      k = 0;
      do begin tick; k++; end while (!done && k < 100);
      check("done_seen", done, 1);
      tick;
      check("done_pulse", done, 0);
   endtask
   // PISO model: evaluates mid-cycle what the PISO does at the coming edge
   always @(negedge clk) begin : piso_model
      gexp_t e;
      if (rst) pcnt = 0;
      else begin
         if (gnt != 0) begin
            if (gq.size() == 0) check("gnt_unexpected", gnt, 0);
            else begin
               e = gq.pop_front();
               check("gnt", gnt, e.g);
               check("owner", owner, e.o);
               check("piso_pi", piso_pi, e.w);
               check("we_with_gnt", piso_we, 1);
            end
         end
         if (done) begin
            n_done++;
            check("done_after_last_chunk", pcnt, 0);
         end
         if (piso_we) begin
            sreg = piso_pi;
            pcnt = D;
         end else if (pcnt > 0 && !halt) begin
            if (cq.size() == 0) check("chunk_extra", 1, 0);
            else check("chunk", sreg[DW-1 -: W], cq.pop_front());
            sreg = sreg << W;
            pcnt--;
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int t, tp, d0;
      rst = 1'b1; req = '0; halt = 1'b0;
      req_data = {wd(3), wd(2), wd(1), wd(0)};
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_we", piso_we, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_owner", owner, 0);
      check("rst_pi", piso_pi, 0);
      tick; tick; rst = 1'b0;
      // single request
      expect_txn(0); req = 4'b0001;
      tick;
      check("t1_gnt", gnt, 4'b0001);
      check("t1_we", piso_we, 1);
      check("t1_pi", piso_pi, 64'h0102030405060708);
      check("t1_busy", busy, 1);
      req = '0;
      for (int c = 2; c <= 9; c++) begin
         tick;
         check("t1_busy", busy, 1);
         check("t1_nodone", done, 0);
         check("t1_we_low", piso_we, 0);
      end
      tick;
      check("t1_done", done, 1);
      check("t1_idle", busy, 0);
      tick;
      check("t1_done_pulse", done, 0);
      check("t1_chunks_left", cq.size(), 0);
      // round-robin with all requesting
      rst = 1'b1; tick; rst = 1'b0;
      for (int i = 0; i < 5; i++) expect_txn(i % 4);
      d0 = n_done; req = '1;
      wait_gnt(tp);
      for (int i = 1; i < 5; i++) begin
         wait_gnt(t);
         check("t2_spacing", t - tp, 10);
         tp = t;
      end
      req = '0;
      wait_done;
      check("t2_dones", n_done - d0, 5);
      // back-pressure
      expect_txn(0); req = 4'b0001;
      tick;
      check("t3_gnt", gnt, 4'b0001);
      req = '0;
      for (int c = 2; c <= 12; c++) begin
         tick;
         halt = (c >= 3 && c <= 5);
         check("t3_busy", busy, 1);
         check("t3_nodone", done, 0);
      end
      tick;
      check("t3_done_c13", done, 1);
      tick;
      check("t3_chunks_left", cq.size(), 0);
      // late request
      expect_txn(0); expect_txn(1); req = 4'b0001;
      tick;
      check("t5_gnt0", gnt, 4'b0001);
      req = '0;
      for (int c = 2; c <= 9; c++) begin
         tick;
         if (c == 4) req = 4'b0010;
         check("t5_no_gnt", gnt, 0);
      end
      tick;
      check("t5_done", done, 1);
      check("t5_no_gnt_at_done", gnt, 0);
      tick;
      check("t5_gnt1", gnt, 4'b0010);
      check("t5_owner1", owner, 1);
      req = '0;
      wait_done;
      // async reset mid-shift
      expect_txn(1); req = 4'b0010;
      tick;
      check("t4_gnt", gnt, 4'b0010);
      req = '0;
      tick; tick;
      #2 rst = 1'b1;
      #1;
      check("t4_busy", busy, 0);
      check("t4_gnt0", gnt, 0);
      check("t4_we", piso_we, 0);
      check("t4_done", done, 0);
      check("t4_owner", owner, 0);
      cq.delete(); gq.delete();
      tick; rst = 1'b0;
      expect_txn(2); req = 4'b0100;
      tick;
      check("t4_gnt2", gnt, 4'b0100);
      check("t4_owner2", owner, 2);
      req = '0;
      wait_done;
      // 1001 held: fixed priority or alternation
      rst = 1'b1; tick; rst = 1'b0;
`ifdef PISO_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) expect_txn(0);
`else
      for (int i = 0; i < 4; i++) expect_txn((i % 2) * 3);
`endif
      req = 4'b1001;
      for (int i = 0; i < 4; i++) wait_gnt(t);
      req = '0;
      wait_done;
      check("end_gnt_queue", gq.size(), 0);
      check("end_chunk_queue", cq.size(), 0);
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule

// File: doc/piso_arbiter.md
Name: piso_arbiter

Overview:
Round-robin controller that shares one PISO serializer (DEPTH chunks of WIDTH bits) between N_REQ requesters. Each requester presents a full parallel word. The arbiter selects one requester, registers its word onto the PISO parallel bus and pulses the PISO write-enable. It then mirrors the PISO shift count, including downstream halt back-pressure, and signals completion before it arbitrates again. The block sits between the requesting engines and the PISO; its halt input is wired to the same halt signal as the PISO.

Parameters:
N_REQ, 4, number of requesters (>= 2)
DEPTH, 8, chunks per PISO word; must match the PISO instance
WIDTH, 8, bits per chunk; must match the PISO instance
OWNER_W, $clog2(N_REQ), width of owner index (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req  input  N_REQ  per-requester request level
req_data  input  N_REQ*DEPTH*WIDTH  parallel words; requester i occupies slice [i*DEPTH*WIDTH +: DEPTH*WIDTH]
gnt  output  N_REQ  one-hot grant pulse, one cycle
piso_pi  output  DEPTH*WIDTH  registered word to PISO pi
piso_we  output  1  PISO write-enable pulse, one cycle
halt  input  1  same signal as PISO halt; a chunk shifts only on an edge where halt=0
busy  output  1  high from the grant cycle through the last shift
owner  output  OWNER_W  index of the current or most recent grantee
done  output  1  one-cycle pulse after the last chunk shifts

Behaviour:
- Reset (async, immediate, no clock needed): state=IDLE; gnt=0, piso_pi=0, piso_we=0, busy=0, owner=0, done=0, rr pointer=0, chunk counter=0.
- Registers: all outputs are registered.
- Counter: counts DEPTH down to 0; width is $clog2(DEPTH+1).
- States: IDLE, LOAD, SHIFT.
- IDLE, req != 0 at an edge:
  - Select the first set bit searching upward from the rr pointer, wrapping modulo N_REQ.
  - Register the selected slice into piso_pi; set gnt=onehot(sel), piso_we=1, owner=sel, busy=1.
  - Load counter=DEPTH; set rr pointer=(sel+1) mod N_REQ; go to LOAD.
- IDLE, req == 0: hold all registers; gnt, piso_we and done are 0.
- LOAD (exactly one cycle): piso_we=1 and gnt visible; the PISO captures piso_pi at the closing edge. gnt and piso_we return to 0; go to SHIFT. The counter does not decrement on this edge.
- SHIFT, each edge:
  - halt=1: hold.
  - halt=0: counter -= 1.
  - halt=0 with counter==1: counter=0, done=1, busy=0, go to IDLE.
- done and busy=0 appear in the same cycle. IDLE may arbitrate in that cycle, so the minimum transaction period with no halt is DEPTH+2 cycles.
- Request rules:
  - The word is captured at the grant decision edge, so the requester may change req_data from the cycle gnt is visible.
  - The requester must drop req in the gnt cycle unless it wants a further transaction; LOAD/SHIFT ignore req.
  - Requests arriving outside IDLE wait; there is no queueing beyond the req level.
- piso_pi holds its value after LOAD (don't-care to the PISO, kept stable for debug).
- owner holds until the next grant.
- Reset mid-transaction: the controller returns to IDLE immediately. The PISO shares rst, so both restart clean; no done pulse is issued for the aborted word.
- halt held high indefinitely: the controller stays in SHIFT. There is no timeout.

Optional Feature:
Macro PISO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest set req index always wins, and the rr pointer is not implemented.
- Undefined (default): round-robin as described above.
- Timing is identical in both modes.

Test Plan:
1. Single request: reset; req=0001, req_data[63:0]=0x0102030405060708, halt=0 held; req raised before edge 0, dropped in the gnt cycle.
   - Cycle 1: gnt=0001, piso_we=1, piso_pi=0x0102030405060708, owner=0.
   - busy=1 in cycles 1-9.
   - Cycle 10: done=1, busy=0.
   - The PISO emits 0x01..0x08 in order.
2. Round-robin: req=1111 held, halt=0.
   - Grants in order 0001, 0010, 0100, 1000, 0001, spaced 10 cycles apart.
   - Exactly one done per grant.
3. Back-pressure: as test 1, with halt=1 for 3 cycles during SHIFT.
   - done at cycle 13.
   - Counter freezes while halt=1; no chunk is lost or duplicated at the PISO.
4. Async reset mid-SHIFT: assert rst between edges.
   - busy, gnt, piso_we, done, owner go to 0 without a clock edge.
   - After release, req=0100 produces gnt=0100, owner=2 at cycle 1.
5. Late request: req=0010 raised while owner 0 is in SHIFT.
   - No gnt until done.
   - gnt=0010 follows in the cycle after done.
6. With PISO_ARB_FIXED_PRIO_EN: req=1001 held.
   - Every grant is 0001; gnt[3] never asserts.
   - Without the macro, grants alternate 0001, 1000.
